// File: rtl/ysyx_22050710_mdu_if.sv
// Issue/result handshake between the EX stage and the iterative multiply/divide unit.
interface ysyx_22050710_mdu_if #(
    parameter int unsigned WORD_WD = 64,
    parameter int unsigned OP_WD   = 5
);
    logic               i_flush;
    logic               i_in_valid;
    logic               o_in_ready;
    logic [WORD_WD-1:0] i_src_a;
    logic [WORD_WD-1:0] i_src_b;
    logic [OP_WD-1:0]   i_op;
    logic               i_word_sel;
    logic               o_out_valid;
    logic               i_out_ready;
    logic [WORD_WD-1:0] o_result;

    modport master (
        output i_flush, i_in_valid, i_src_a, i_src_b, i_op, i_word_sel, i_out_ready,
        input  o_in_ready, o_out_valid, o_result
    );

    modport slave (
        input  i_flush, i_in_valid, i_src_a, i_src_b, i_op, i_word_sel, i_out_ready,
        output o_in_ready, o_out_valid, o_result
    );
endinterface

// File: rtl/ysyx_22050710_mdu.sv
// Iterative RV64M multiply/divide unit: shift-add multiplier and restoring divider,
// one bit per cycle, with a single-cycle path for divide-by-zero, overflow and unknown ops.
module ysyx_22050710_mdu #(
    parameter int unsigned WORD_WD = 64,
    parameter int unsigned OP_WD   = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    ysyx_22050710_mdu_if.slave bus
);
    localparam int unsigned W      = WORD_WD;
    localparam int unsigned W2     = 2 * WORD_WD;
    localparam int unsigned CNT_WD = $clog2(WORD_WD);

    localparam logic [OP_WD-1:0] OP_MUL    = OP_WD'(5'b01010);
    localparam logic [OP_WD-1:0] OP_MULH   = OP_WD'(5'b11001);
    localparam logic [OP_WD-1:0] OP_MULHSU = OP_WD'(5'b11010);
    localparam logic [OP_WD-1:0] OP_MULHU  = OP_WD'(5'b11011);
    localparam logic [OP_WD-1:0] OP_DIV    = OP_WD'(5'b01011);
    localparam logic [OP_WD-1:0] OP_DIVU   = OP_WD'(5'b01100);
    localparam logic [OP_WD-1:0] OP_REM    = OP_WD'(5'b01101);
    localparam logic [OP_WD-1:0] OP_REMU   = OP_WD'(5'b01110);

    localparam logic [W-1:0] MIN_FULL = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [CNT_WD-1:0] cnt;
    logic              word_q, neg_q, rneg_q, mul_q, mul_hi_q, quo_q;
    logic [W2-1:0]     mcand, prod;
    logic [W-1:0]      mplier, dq, rem, dvsr;
    logic              out_valid_q;
    logic [W-1:0]      result_q;

    // Word results are the low 32 bits sign-extended to the datapath width.
    function automatic logic [W-1:0] fmt(input logic [W-1:0] r, input logic w);
        return w ? W'($signed(r[31:0])) : r;
    endfunction

    logic is_mul, is_mulh, is_mulhsu, is_mulhu, is_div, is_divu, is_rem, is_remu;
    logic word_en, mul_op, div_op, sgn_a, sgn_b, a_neg, b_neg, div_zero, ovf, fast;
    logic [W-1:0] a_ext, b_ext, a_mag, b_mag, min_neg, fast_res;

    assign is_mul    = (bus.i_op == OP_MUL);
    assign is_mulh   = (bus.i_op == OP_MULH);
    assign is_mulhsu = (bus.i_op == OP_MULHSU);
    assign is_mulhu  = (bus.i_op == OP_MULHU);
    assign is_div    = (bus.i_op == OP_DIV);
    assign is_divu   = (bus.i_op == OP_DIVU);
    assign is_rem    = (bus.i_op == OP_REM);
    assign is_remu   = (bus.i_op == OP_REMU);

    assign word_en = (W == 64) && bus.i_word_sel;
    assign mul_op  = is_mul | is_mulh | is_mulhsu | is_mulhu;
    assign div_op  = is_div | is_divu | is_rem | is_remu;
    assign sgn_a   = is_mul | is_mulh | is_mulhsu | is_div | is_rem;
    assign sgn_b   = is_mul | is_mulh | is_div | is_rem;

    assign a_ext = !word_en ? bus.i_src_a :
                   sgn_a    ? W'($signed(bus.i_src_a[31:0])) : W'(bus.i_src_a[31:0]);
    assign b_ext = !word_en ? bus.i_src_b :
                   sgn_b    ? W'($signed(bus.i_src_b[31:0])) : W'(bus.i_src_b[31:0]);

    // The core runs on magnitudes; the most-negative value maps to 2^(N-1) unsigned.
    assign a_neg = sgn_a & a_ext[W-1];
    assign b_neg = sgn_b & b_ext[W-1];
    assign a_mag = a_neg ? -a_ext : a_ext;
    assign b_mag = b_neg ? -b_ext : b_ext;

    assign min_neg  = word_en ? W'($signed(32'h8000_0000)) : MIN_FULL;
    assign div_zero = div_op && (b_ext == '0);
    assign ovf      = (is_div | is_rem) && (a_ext == min_neg) && (b_ext == '1);
    assign fast     = (!mul_op && !div_op) || div_zero || ovf;

    always_comb begin
        fast_res = '0;
        if (div_zero)
            fast_res = (is_div | is_divu) ? '1 : a_ext;
        else if (ovf)
            fast_res = is_div ? a_ext : '0;
    end

    // Next iteration step; the final step also feeds the sign fix and formatting.
    logic [W+1:0]  div_diff;
    logic          borrow;
    logic [W2-1:0] prod_nxt, prod_s;
    logic [W-1:0]  rem_nxt, dq_nxt, quo_s, rem_s, mul_res, div_res, fin_res;
    logic [CNT_WD-1:0] last_cnt;

    assign prod_nxt = mplier[0] ? prod + mcand : prod;
    assign div_diff = {1'b0, rem, dq[W-1]} - {2'b00, dvsr};
    assign borrow   = div_diff[W+1];
    assign rem_nxt  = borrow ? {rem[W-2:0], dq[W-1]} : div_diff[W-1:0];
    assign dq_nxt   = {dq[W-2:0], ~borrow};

    assign prod_s  = neg_q ? -prod_nxt : prod_nxt;
    assign quo_s   = neg_q ? -dq_nxt : dq_nxt;
    assign rem_s   = rneg_q ? -rem_nxt : rem_nxt;
    assign mul_res = !mul_hi_q ? prod_s[W-1:0] :
                     word_q    ? W'(prod_s[63:32]) : prod_s[W2-1:W];
    assign div_res = quo_q ? quo_s : rem_s;
    assign fin_res = fmt(mul_q ? mul_res : div_res, word_q);

    assign last_cnt = word_q ? CNT_WD'(31) : CNT_WD'(W - 1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else if (bus.i_flush) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.i_in_valid) begin
                        cnt      <= '0;
                        word_q   <= word_en;
                        neg_q    <= a_neg ^ b_neg;
                        rneg_q   <= a_neg;
                        mul_q    <= mul_op;
                        mul_hi_q <= is_mulh | is_mulhsu | is_mulhu;
                        quo_q    <= is_div | is_divu;
                        mcand    <= W2'(a_mag);
                        mplier   <= b_mag;
                        prod     <= '0;
                        // Word dividends are pre-aligned so the MSB walk starts at bit 31.
                        dq       <= word_en ? (a_mag << 32) : a_mag;
                        rem      <= '0;
                        dvsr     <= b_mag;
                        if (fast) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= fmt(fast_res, word_en);
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (mul_q) begin
                        prod   <= prod_nxt;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end else begin
                        rem <= rem_nxt;
                        dq  <= dq_nxt;
                    end
                    if (cnt == last_cnt) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= fin_res;
                    end else begin
                        cnt <= cnt + CNT_WD'(1);
                    end
                end
                DONE: begin
                    if (bus.i_out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_in_ready  = (state == IDLE) && !i_rst;
    assign bus.o_out_valid = out_valid_q;
    assign bus.o_result    = result_q;
endmodule

// File: tb/tb_ysyx_22050710_mdu.sv
// Directed and randomized checks of the multiply/divide unit against an arithmetic model.
module tb_ysyx_22050710_mdu;
    localparam logic [4:0] OP_MUL    = 5'b01010;
    localparam logic [4:0] OP_MULH   = 5'b11001;
    localparam logic [4:0] OP_MULHSU = 5'b11010;
    localparam logic [4:0] OP_MULHU  = 5'b11011;
    localparam logic [4:0] OP_DIV    = 5'b01011;
    localparam logic [4:0] OP_DIVU   = 5'b01100;
    localparam logic [4:0] OP_REM    = 5'b01101;
    localparam logic [4:0] OP_REMU   = 5'b01110;
    localparam logic [63:0] ONES     = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN64    = 64'h8000_0000_0000_0000;
    localparam logic [63:0] NEG7     = 64'hFFFF_FFFF_FFFF_FFF9;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    ysyx_22050710_mdu_if #(.WORD_WD(64), .OP_WD(5)) bus ();

    ysyx_22050710_mdu #(.WORD_WD(64), .OP_WD(5)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    // Reference: RISC-V M semantics computed with native SV arithmetic.
    task automatic model(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic w, output logic [63:0] r, output bit fast);
        longint      sa, sb;
        int          sa32, sb32;
        int unsigned ua32, ub32;
        logic [127:0] p;
        sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
        fast = 1'b0;
        r = '0;
        case (op)
            OP_MUL:    r = w ? sx32(32'(a[31:0] * b[31:0])) : a * b;
            OP_MULH:   begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
            OP_MULHSU: begin p = {{64{a[63]}}, a} * {64'b0, b};       r = p[127:64]; end
            OP_MULHU:  begin p = {64'b0, a} * {64'b0, b};             r = p[127:64]; end
            OP_DIV: begin
                if (w) begin
                    if (sb32 == 0) begin fast = 1'b1; r = ONES; end
                    else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
                        fast = 1'b1; r = sx32(a[31:0]);
                    end else r = sx32(32'(sa32 / sb32));
                end else begin
                    if (b == 64'd0) begin fast = 1'b1; r = ONES; end
                    else if (a == MIN64 && b == ONES) begin fast = 1'b1; r = a; end
                    else r = 64'(sa / sb);
                end
            end
            OP_DIVU: begin
                if (w) begin
                    if (ub32 == 0) begin fast = 1'b1; r = ONES; end
                    else r = sx32(ua32 / ub32);
                end else begin
                    if (b == 64'd0) begin fast = 1'b1; r = ONES; end
                    else r = a / b;
                end
            end
            OP_REM: begin
                if (w) begin
                    if (sb32 == 0) begin fast = 1'b1; r = sx32(a[31:0]); end
                    else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
                        fast = 1'b1; r = 64'd0;
                    end else r = sx32(32'(sa32 % sb32));
                end else begin
                    if (b == 64'd0) begin fast = 1'b1; r = a; end
                    else if (a == MIN64 && b == ONES) begin fast = 1'b1; r = 64'd0; end
                    else r = 64'(sa % sb);
                end
            end
            OP_REMU: begin
                if (w) begin
                    if (ub32 == 0) begin fast = 1'b1; r = sx32(a[31:0]); end
                    else r = sx32(ua32 % ub32);
                end else begin
                    if (b == 64'd0) begin fast = 1'b1; r = a; end
                    else r = a % b;
                end
            end
            default: begin fast = 1'b1; r = 64'd0; end
        endcase
    endtask

    // Issue one op, scramble inputs after accept, measure latency and result, then consume.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic w, input logic [63:0] exp_r,
                          input int exp_lat);
        int lat;
        @(negedge clk);
        check({tag, ":ready"}, 64'(bus.o_in_ready), 64'd1);
        bus.i_op = op; bus.i_src_a = a; bus.i_src_b = b; bus.i_word_sel = w;
        bus.i_in_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_in_valid = 1'b0;
        bus.i_src_a = {$urandom, $urandom};
        bus.i_src_b = {$urandom, $urandom};
        bus.i_op = 5'($urandom);
        bus.i_word_sel = ~w;
        lat = 1;
        while (bus.o_out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ":latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ":result"}, bus.o_result, exp_r);
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        bus.i_op = op; bus.i_src_a = a; bus.i_src_b = b; bus.i_word_sel = 1'b0;
        bus.i_in_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_in_valid = 1'b0;
    endtask

    initial begin
        logic [4:0]  ops [9];
        logic [4:0]  op;
        logic [63:0] a, b, r;
        logic        w;
        bit          fast, seen;
        int          lat;
        ops = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, 5'b00000};

        rst = 1'b1;
        bus.i_flush = 1'b0; bus.i_in_valid = 1'b0; bus.i_out_ready = 1'b1;
        bus.i_src_a = '0; bus.i_src_b = '0; bus.i_op = '0; bus.i_word_sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.o_in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.o_out_valid), 64'd0);
        check("rst_result", bus.o_result, 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", 64'(bus.o_in_ready), 64'd1);

        run_op("div_neg7_2",  OP_DIV,    NEG7, 64'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run_op("rem_neg7_2",  OP_REM,    NEG7, 64'd2, 1'b0, ONES, 65);
        run_op("divu_by0",    OP_DIVU,   64'd5, 64'd0, 1'b0, ONES, 1);
        run_op("remu_by0",    OP_REMU,   64'd5, 64'd0, 1'b0, 64'd5, 1);
        run_op("div_ovf",     OP_DIV,    MIN64, ONES, 1'b0, MIN64, 1);
        run_op("rem_ovf",     OP_REM,    MIN64, ONES, 1'b0, 64'd0, 1);
        run_op("mulhu_ones",  OP_MULHU,  ONES, ONES, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run_op("mulh_m1_m1",  OP_MULH,   ONES, ONES, 1'b0, 64'd0, 65);
        run_op("mulhsu_m1_2", OP_MULHSU, ONES, 64'd2, 1'b0, ONES, 65);
        run_op("mul_3_m4",    OP_MUL,    64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0,
               64'hFFFF_FFFF_FFFF_FFF4, 65);
        run_op("divuw",       OP_DIVU,   64'h1_FFFF_FFFE, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        run_op("mulw",        OP_MUL,    64'h7FFF_FFFF, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        run_op("remw",        OP_REM,    NEG7, 64'd2, 1'b1, ONES, 33);
        run_op("bad_op",      5'b00001,  64'd9, 64'd3, 1'b0, 64'd0, 1);

        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 8)];
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: b = 64'd0;
                1: begin a = MIN64; b = ONES; end
                2: b = 64'($urandom_range(1, 20));
                default: ;
            endcase
            w = (op == OP_MUL || op == OP_DIV || op == OP_DIVU || op == OP_REM || op == OP_REMU)
                ? 1'($urandom_range(0, 1)) : 1'b0;
            if (w && a == MIN64) a = 64'h8000_0000;
            model(op, a, b, w, r, fast);
            run_op($sformatf("rnd%0d_op%b_w%0d", i, op, w), op, a, b, w, r, fast ? 1 : (w ? 33 : 65));
        end

        // Back-pressure: result held and no new accept while the consumer stalls.
        bus.i_out_ready = 1'b0;
        issue(OP_DIVU, 64'd100, 64'd7);
        lat = 1;
        while (bus.o_out_valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
        check("bp_latency", 64'(lat), 64'd65);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 64'(bus.o_out_valid), 64'd1);
            check("bp_result", bus.o_result, 64'd14);
            check("bp_ready", 64'(bus.o_in_ready), 64'd0);
        end
        @(negedge clk); bus.i_out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 64'(bus.o_out_valid), 64'd0);
        check("bp_release_ready", 64'(bus.o_in_ready), 64'd1);

        // Flush in the middle of an iteration.
        issue(OP_DIV, 64'd1000, 64'd3);
        repeat (19) @(posedge clk);
        @(negedge clk); bus.i_flush = 1'b1;
        @(posedge clk); #1; bus.i_flush = 1'b0;
        check("flush_busy_ready", 64'(bus.o_in_ready), 64'd1);
        check("flush_busy_valid", 64'(bus.o_out_valid), 64'd0);
        seen = 1'b0;
        repeat (80) begin @(posedge clk); #1; if (bus.o_out_valid === 1'b1) seen = 1'b1; end
        check("flush_busy_no_result", 64'(seen), 64'd0);

        // Flush together with a request: nothing accepted.
        @(negedge clk);
        bus.i_op = OP_DIV; bus.i_src_a = 64'd50; bus.i_src_b = 64'd5; bus.i_word_sel = 1'b0;
        bus.i_flush = 1'b1; bus.i_in_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_flush = 1'b0; bus.i_in_valid = 1'b0;
        check("flush_accept_ready", 64'(bus.o_in_ready), 64'd1);
        seen = 1'b0;
        repeat (80) begin @(posedge clk); #1; if (bus.o_out_valid === 1'b1) seen = 1'b1; end
        check("flush_accept_no_result", 64'(seen), 64'd0);

        // Reset while busy clears the held result and re-opens the input.
        issue(OP_MUL, 64'd6, 64'd7);
        repeat (10) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", 64'(bus.o_in_ready), 64'd0);
        check("midrst_valid", 64'(bus.o_out_valid), 64'd0);
        check("midrst_result", bus.o_result, 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("post_midrst_ready", 64'(bus.o_in_ready), 64'd1);
        check("post_midrst_valid", 64'(bus.o_out_valid), 64'd0);

        run_op("after_rst_mul", OP_MUL, 64'd6, 64'd7, 1'b0, 64'd42, 65);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
